// File: rtl/e203_reset_seq_pkg.sv
// e203_reset_seq_pkg: shared state encoding, default parameters and counter sizing
// for the staged reset sequencer. Rev 1.0
`default_nettype none

package e203_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_SYNC   = 3'd1,
    ST_REL    = 3'd2,
    ST_RUN    = 3'd3,
    ST_SWHOLD = 3'd4
  } seq_state_e;

  localparam int c_NCH_DEF      = 4;
  localparam int c_SYNC_LVL_DEF = 2;
  localparam int c_STEP_CYC_DEF = 8;
  localparam int c_HOLD_CYC_DEF = 16;

  // Wide enough to hold the largest reload value of the three delays.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e203_reset_seq_cnt.sv
// e203_reset_seq_cnt: loadable saturating down-counter with a zero flag. Rev 1.0
`default_nettype none

module e203_reset_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/e203_reset_seq.sv
// e203_reset_seq: releases NCH reset domains in index order; software re-reset of a
// channel and its dependents exists only when E203_RST_SEQ_SWRST_EN is defined. Rev 1.0
`default_nettype none

module e203_reset_seq
  import e203_reset_seq_pkg::*;
#(
  parameter int NCH      = c_NCH_DEF,
  parameter int SYNC_LVL = c_SYNC_LVL_DEF,
  parameter int STEP_CYC = c_STEP_CYC_DEF,
  parameter int HOLD_CYC = c_HOLD_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           test_mode,
  input  logic [NCH-1:0] sw_rst_req,
  output logic [NCH-1:0] rst_out_n,
  output logic           seq_busy,
  output logic           seq_done
);

  localparam int c_CNT_W = cnt_width(SYNC_LVL, STEP_CYC, HOLD_CYC);
  localparam int c_IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [c_CNT_W-1:0] c_SYNC_LD = c_CNT_W'(SYNC_LVL - 1);
  localparam logic [c_CNT_W-1:0] c_STEP_LD = c_CNT_W'(STEP_CYC - 1);
  localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(NCH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

  seq_state_e           state_q;
  logic [c_IDX_W-1:0]   idx_q;
  logic [NCH-1:0]       rst_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 w_zero;
  logic                 w_load;
  logic [c_CNT_W-1:0]   w_load_val;

`ifdef E203_RST_SEQ_SWRST_EN
  localparam logic [c_CNT_W-1:0] c_HOLD_LD = c_CNT_W'(HOLD_CYC - 1);

  logic                 w_sw_go;
  logic [c_IDX_W-1:0]   w_k;
  logic [NCH-1:0]       w_keep;

  assign w_sw_go = (|sw_rst_req) & ~test_mode;

  // k is the lowest requested channel; everything below k keeps running.
  always_comb begin
    w_k    = '0;
    w_keep = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (sw_rst_req[i]) w_k = c_IDX_W'(i);
    end
    for (int i = 0; i < NCH; i++) begin
      w_keep[i] = (c_IDX_W'(i) < w_k);
    end
  end
`else
  logic w_sw_unused;
  assign w_sw_unused = ^sw_rst_req;
`endif

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (state_q)
      ST_RESET: begin
        w_load     = 1'b1;
        w_load_val = c_SYNC_LD;
      end
      ST_SYNC, ST_REL: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = c_STEP_LD;
        end
      end
`ifdef E203_RST_SEQ_SWRST_EN
      ST_RUN: begin
        if (w_sw_go) begin
          w_load     = 1'b1;
          w_load_val = c_HOLD_LD;
        end
      end
      ST_SWHOLD: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = c_STEP_LD;
        end
      end
`endif
      default: ;
    endcase
  end

  e203_reset_seq_cnt #(
    .W (c_CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .zero_o     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      idx_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RESET: state_q <= ST_SYNC;
        ST_SYNC: begin
          if (w_zero) begin
            rst_q[0] <= 1'b1;
            if (NCH == 1) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_REL;
              idx_q   <= c_IDX_ONE;
            end
          end
        end
        ST_REL: begin
          if (w_zero) begin
            rst_q[idx_q] <= 1'b1;
            if (idx_q == c_LAST) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + c_IDX_ONE;
            end
          end
        end
`ifdef E203_RST_SEQ_SWRST_EN
        ST_RUN: begin
          if (w_sw_go) begin
            rst_q   <= rst_q & w_keep;
            idx_q   <= w_k;
            state_q <= ST_SWHOLD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        // idx_q holds k here, so the tail of the release reuses the REL walk.
        ST_SWHOLD: begin
          if (w_zero) begin
            rst_q[idx_q] <= 1'b1;
            if (idx_q == c_LAST) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + c_IDX_ONE;
              state_q <= ST_REL;
            end
          end
        end
`else
        ST_RUN: ;
`endif
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign rst_out_n = test_mode ? {NCH{rst_n}} : rst_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_e203_reset_seq.sv
// tb_e203_reset_seq: table-driven directed vectors for the default 4-channel build plus
// a hand-written sequence for a 1-channel, SYNC_LVL=1 instance.
`default_nettype none

module tb_e203_reset_seq;

`ifdef E203_RST_SEQ_SWRST_EN
  localparam bit SWEN = 1'b1;
`else
  localparam bit SWEN = 1'b0;
`endif

  typedef struct {
    int         n;
    logic       rn;
    logic       tm;
    logic [3:0] sw;
    logic [3:0] eo;
    logic       eb;
    logic       ed;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_mode = 1'b0;
  logic [3:0] sw_rst_req = '0;
  logic [3:0] rst_out_n;
  logic       seq_busy;
  logic       seq_done;

  logic       rst1_n = 1'b0;
  logic       sw1 = 1'b0;
  logic       out1_n;
  logic       busy1;
  logic       done1;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  e203_reset_seq #(
    .NCH(4), .SYNC_LVL(2), .STEP_CYC(8), .HOLD_CYC(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .test_mode  (test_mode),
    .sw_rst_req (sw_rst_req),
    .rst_out_n  (rst_out_n),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done)
  );

  e203_reset_seq #(
    .NCH(1), .SYNC_LVL(1), .STEP_CYC(8), .HOLD_CYC(16)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst1_n),
    .test_mode  (1'b0),
    .sw_rst_req (sw1),
    .rst_out_n  (out1_n),
    .seq_busy   (busy1),
    .seq_done   (done1)
  );

  function automatic vec_t mk(input int n, input logic rn, input logic tm,
                              input logic [3:0] sw, input logic [3:0] eo,
                              input logic eb, input logic ed);
    vec_t v;
    v.n = n; v.rn = rn; v.tm = tm; v.sw = sw; v.eo = eo; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  function automatic logic [3:0] sel(input logic [3:0] on, input logic [3:0] off);
    return SWEN ? on : off;
  endfunction

  task automatic chk1(input string nm, input logic eo, input logic eb, input logic ed);
    n_vec++;
    if ({out1_n, busy1, done1} !== {eo, eb, ed}) begin
      n_err++;
      $display("FAIL nch1_%s: out=%b busy=%b done=%b expected out=%b busy=%b done=%b",
               nm, out1_n, busy1, done1, eo, eb, ed);
    end
  endtask

  initial begin
    // power-up, E = first edge sampling rst_n=1
    tbl.push_back(mk(3, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(mk(7, 1, 0, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 4'b0011, 1, 0));
    tbl.push_back(mk(7, 1, 0, 4'b0000, 4'b0011, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 4'b0111, 1, 0));
    tbl.push_back(mk(7, 1, 0, 4'b0000, 4'b0111, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 4'b1111, 0, 1));
    tbl.push_back(mk(3, 1, 0, 4'b0000, 4'b1111, 0, 1));
    // software reset of channel 2 (k=2)
    tbl.push_back(mk(1,  1, 0, 4'b0100, sel(4'b0011, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(15, 1, 0, 4'b0000, sel(4'b0011, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(1,  1, 0, 4'b0000, sel(4'b0111, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(7,  1, 0, 4'b0000, sel(4'b0111, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 4'b1111, 0, 1));
    // k=1 from 4'b1010, second request during hold must be dropped
    tbl.push_back(mk(1,  1, 0, 4'b1010, sel(4'b0001, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(1,  1, 0, 4'b0001, sel(4'b0001, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(14, 1, 0, 4'b0000, sel(4'b0001, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(1,  1, 0, 4'b0000, sel(4'b0011, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(8,  1, 0, 4'b0000, sel(4'b0111, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(7,  1, 0, 4'b0000, sel(4'b0111, 4'b1111), SWEN, !SWEN));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 4'b1111, 0, 1));
    // rst_n drop mid-REL, then full re-release
    tbl.push_back(mk(2,  0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(11, 1, 0, 4'b0000, 4'b0011, 1, 0));
    tbl.push_back(mk(1,  0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(mk(8,  1, 0, 4'b0000, 4'b0011, 1, 0));
    tbl.push_back(mk(16, 1, 0, 4'b0000, 4'b1111, 0, 1));
    // test_mode bypass (n=0 checks are zero-latency)
    tbl.push_back(mk(0,  1, 1, 4'b0000, 4'b1111, 0, 1));
    tbl.push_back(mk(0,  0, 1, 4'b0000, 4'b0000, 0, 1));
    tbl.push_back(mk(1,  0, 1, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(0,  1, 1, 4'b0000, 4'b1111, 1, 0));
    tbl.push_back(mk(30, 1, 1, 4'b0000, 4'b1111, 0, 1));
    tbl.push_back(mk(1,  1, 1, 4'b1111, 4'b1111, 0, 1));
    tbl.push_back(mk(1,  1, 0, 4'b0000, 4'b1111, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n      = tbl[i].rn;
      test_mode  = tbl[i].tm;
      sw_rst_req = tbl[i].sw;
      if (tbl[i].n == 0) #1;
      else repeat (tbl[i].n) @(negedge clk);
      n_vec++;
      if ({rst_out_n, seq_busy, seq_done} !== {tbl[i].eo, tbl[i].eb, tbl[i].ed}) begin
        n_err++;
        $display("FAIL vec%0d: out=%b busy=%b done=%b expected out=%b busy=%b done=%b",
                 i, rst_out_n, seq_busy, seq_done, tbl[i].eo, tbl[i].eb, tbl[i].ed);
      end
    end

    // single-channel instance, SYNC_LVL=1
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    chk1("reset", 1'b0, 1'b1, 1'b0);
    rst1_n = 1'b1;
    @(negedge clk);
    chk1("edgeE", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk1("release", 1'b1, 1'b0, 1'b1);
    sw1 = 1'b1;
    @(negedge clk);
    chk1("swreq", SWEN ? 1'b0 : 1'b1, SWEN, !SWEN);
    sw1 = 1'b0;
    repeat (15) @(negedge clk);
    chk1("hold15", SWEN ? 1'b0 : 1'b1, SWEN, !SWEN);
    @(negedge clk);
    chk1("hold16", 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
